l_modu01_keypad: RTL and testbench
==================================

# l_modu01_keypad

Matrix-keypad entry block for the code lock. It scans a 4x4 keypad, debounces key presses and assembles a 4-digit BCD entry in a 16-bit `Code` register. `Code` feeds the seven-segment display stage directly: digits not yet entered read 4'hA, which the display renders as blank. On a confirmed entry the block emits a one-cycle `CODE_VALID` pulse to the lock FSM.

## Interface
- `SCAN_DIV`, default 50000: CLK cycles per column slot (must be ≥ 4).
- `DEBOUNCE_SCANS`, default 5: consecutive identical full-scan results required for press and for release (≥ 1).
- `CLK`  in  1  system clock, single clock domain.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `ROW`  in  4  keypad rows, pulled up, 0 = contact. Asynchronous to CLK.
- `COL`  out  4  column drive, exactly one bit low at any time.
- `EN`  in  1  1 = key actions update `Code`; 0 = entry frozen.
- `CLEAR`  in  1  synchronous entry clear from the lock FSM.
- `KEY_PRESS`  out  1  one-cycle pulse per debounced press.
- `KEY_VALUE`  out  4  last debounced key; held between presses.
- `Code`  out  16  entry; nibble i = i-th entered digit, 4'hA = empty.
- `DIGIT_CNT`  out  3  digits entered, 0..4.
- `CODE_VALID`  out  1  one-cycle pulse, entry complete and confirmed.

## Operation
- Reset values:
  - `COL` = 4'b1110, column index 0.
  - `Code` = 16'hAAAA, `DIGIT_CNT` = 0.
  - `KEY_PRESS`, `KEY_VALUE`, `CODE_VALID` = 0.
  - Debounce FSM in IDLE; all counters 0.
- Row synchronisation: `ROW` passes through a 2-flop synchroniser before any use.
- Scanner:
  - The column index advances 0→1→2→3→0 once every `SCAN_DIV` cycles. `COL` drives bit[index] low.
  - Synchronised rows are sampled on the last cycle of each slot.
  - A full scan covers 4 slots.
  - Scan result: index r*4+c if exactly one contact was seen in the scan; "none" if zero contacts or more than one.
- Key map, row-major:
  - Row 0: 1, 2, 3, A.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: *, 0, #, D.
  - Encoding: digits = value; A = 4'hA (enter), B = 4'hB (backspace), C = 4'hC (clear), D = 4'hD, * = 4'hE, # = 4'hF. D, * and # take no action.
- Debounce FSM, evaluated once per full-scan result:
  - IDLE: key K → DEBOUNCE, cand = K, cnt = 1. If `DEBOUNCE_SCANS` = 1, go straight to HELD and pulse.
  - DEBOUNCE: result == cand → cnt++. When cnt reaches `DEBOUNCE_SCANS` → HELD, with `KEY_PRESS` = 1 for one cycle and `KEY_VALUE` = cand. Any other result → IDLE.
  - HELD: "none" → rel++. When rel reaches `DEBOUNCE_SCANS` → IDLE. Any key result → rel = 0.
  - No auto-repeat. Changing keys without a release produces no new press.
- Entry actions are taken on `KEY_PRESS` only when `EN` = 1:
  - Digit with `DIGIT_CNT` < 4: `Code[4*DIGIT_CNT +: 4]` = digit, then `DIGIT_CNT`++. At 4 the digit is ignored.
  - B with `DIGIT_CNT` > 0: `DIGIT_CNT`--, and that nibble returns to 4'hA. At 0 there is no action.
  - C: `Code` = 16'hAAAA, `DIGIT_CNT` = 0.
  - A with `DIGIT_CNT` == 4: `CODE_VALID` = 1 for one cycle with `Code` unchanged. On the following cycle `Code` = 16'hAAAA and `DIGIT_CNT` = 0. With fewer than 4 digits, A is ignored.
- Priority and boundary cases:
  - `CLEAR` beats a same-cycle key action; that key is dropped.
  - `CLEAR` in the cycle `CODE_VALID` is high: the pulse completes and the clear happens as normal.
  - `EN` = 0: the scanner and `KEY_PRESS` keep running; `Code` and `CODE_VALID` are unaffected.
  - Reset mid-scan or mid-debounce returns everything to the reset values immediately.

## Timing
- `COL` changes on the first cycle of each slot.
- Sampling on the last cycle tolerates 2 synchroniser cycles plus settling, which is why `SCAN_DIV` must be ≥ 4.
- Full-scan period: 4*`SCAN_DIV` cycles.
- Press latency: `KEY_PRESS` is high on the cycle after the sample ending the `DEBOUNCE_SCANS`-th consecutive matching scan.
- `Code` and `DIGIT_CNT` update on the cycle after `KEY_PRESS`.
- `CODE_VALID` is high on the cycle after `KEY_PRESS`; the clear lands one cycle later.
- All outputs are registered.

## Test plan
Benches use `SCAN_DIV` = 8 and `DEBOUNCE_SCANS` = 3 (full scan = 32 cycles).
1. Reset:
   - Release reset → `COL` = 1110, `Code` = 16'hAAAA, `DIGIT_CNT` = 0, all pulses 0.
   - `COL` then cycles 1101, 1011, 0111 every 8 cycles.
2. Entry and confirm:
   - Enter keys 1, 2, 3, 4, each held 4 scans and released 4 scans → `Code` = 16'h4321, `DIGIT_CNT` = 4, four single `KEY_PRESS` pulses.
   - Then press A → one `CODE_VALID` pulse with `Code` = 16'h4321; next cycle `Code` = 16'hAAAA.
3. Bounce and invalid contacts:
   - Key 5 present for only 2 scans → no `KEY_PRESS`.
   - Keys 5 and 6 held together → no press.
   - Key 5 held 20 scans → exactly one press.
4. Backspace and overflow:
   - Enter 9, 8, B → `Code` = 16'hAAA9, `DIGIT_CNT` = 1.
   - Enter 4 more digits, so the 5th is ignored → `DIGIT_CNT` = 4.
   - A with 3 digits entered → no `CODE_VALID`.
5. `CLEAR` and `EN`:
   - `CLEAR` on the same cycle as a digit `KEY_PRESS` → `Code` = 16'hAAAA, key dropped.
   - `EN` = 0 while pressing 7 → `KEY_PRESS` = 1 and `KEY_VALUE` = 7, `Code` unchanged.
6. Asynchronous reset during DEBOUNCE with cnt = 2 → FSM returns to IDLE and the key later requires 3 fresh matching scans.

Source files
------------

// File: rtl/l_modu01_keypad.sv
// ---------------------------------------------------------------------------
// l_modu01_keypad
//
// Matrix-keypad entry block for the code lock. It scans a 4x4 keypad one
// column at a time, debounces the full-scan results, and assembles a 4-digit
// BCD entry that the seven-segment stage displays directly. Empty digit
// positions hold 4'hA, which the display renders as blank.
//
// Parameters
//   SCAN_DIV        CLK cycles per column slot (>= 4)
//   DEBOUNCE_SCANS  identical full-scan results needed for press and release
//
// Ports
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   ROW[3:0]    keypad rows, pulled up, 0 = contact, asynchronous to CLK
//   COL[3:0]    column drive, exactly one bit low
//   EN          1 = key actions update the entry, 0 = entry frozen
//   CLEAR       synchronous entry clear, wins over a same-cycle key action
//   KEY_PRESS   one-cycle pulse per debounced press
//   KEY_VALUE   last debounced key code, held between presses
//   Code[15:0]  entry, nibble i = i-th digit entered, 4'hA = empty
//   DIGIT_CNT   number of digits entered, 0..4
//   CODE_VALID  one-cycle pulse when a complete entry is confirmed with A
// ---------------------------------------------------------------------------
module l_modu01_keypad #(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 5
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [3:0]  ROW,
   output logic [3:0]  COL,
   input  logic        EN,
   input  logic        CLEAR,
   output logic        KEY_PRESS,
   output logic [3:0]  KEY_VALUE,
   output logic [15:0] Code,
   output logic [2:0]  DIGIT_CNT,
   output logic        CODE_VALID
);

   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_TARGET   = DB_W'(DEBOUNCE_SCANS);
   localparam bit               SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

   localparam logic [15:0] CODE_EMPTY = 16'hAAAA;
   localparam logic [3:0]  NIB_EMPTY  = 4'hA;
   localparam logic [3:0]  KEY_ENTER  = 4'hA;
   localparam logic [3:0]  KEY_BACK   = 4'hB;
   localparam logic [3:0]  KEY_CLR    = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DEBOUNCE,
      ST_HELD
   } db_state_t;

   // Row-major key position (row*4 + col) to key code.
   function automatic logic [3:0] key_map(input logic [3:0] pos);
      logic [3:0] val;
      case (pos)
         4'd0:    val = 4'h1;
         4'd1:    val = 4'h2;
         4'd2:    val = 4'h3;
         4'd3:    val = 4'hA;
         4'd4:    val = 4'h4;
         4'd5:    val = 4'h5;
         4'd6:    val = 4'h6;
         4'd7:    val = 4'hB;
         4'd8:    val = 4'h7;
         4'd9:    val = 4'h8;
         4'd10:   val = 4'h9;
         4'd11:   val = 4'hC;
         4'd12:   val = 4'hE;
         4'd13:   val = 4'h0;
         4'd14:   val = 4'hF;
         default: val = 4'hD;
      endcase
      return val;
   endfunction

   // ------------------------------------------------------------------------
   // Row synchroniser. Idle value is all-ones (no contact) so a reset never
   // looks like a key.
   // ------------------------------------------------------------------------
   logic [3:0] row_meta;
   logic [3:0] row_sync;

   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; blocking assignments here would collapse the two stages.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         row_meta <= 4'hF;
         row_sync <= 4'hF;
      end else begin
         row_meta <= ROW;
         row_sync <= row_meta;
      end
   end

   // ------------------------------------------------------------------------
   // Column scanner
   // ------------------------------------------------------------------------
   logic [DIV_W-1:0] div_cnt;
   logic [1:0]       col_idx;
   logic [1:0]       next_col;
   logic             slot_end;
   logic             scan_done;

   // Contacts gathered over the earlier columns of the current scan.
   // Counts saturate at 2 since only "one" versus "not one" matters.
   logic [1:0]       acc_hits;
   logic [3:0]       acc_pos;

   logic [1:0]       col_hits;
   logic [1:0]       col_row;
   logic [1:0]       tot_hits;
   logic [3:0]       scan_pos;
   logic             scan_hit;

   assign slot_end  = (div_cnt == DIV_LAST);
   assign scan_done = slot_end && (col_idx == 2'd3);
   assign next_col  = col_idx + 2'd1;

   // NOTE: every signal driven here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      col_hits = 2'd0;
      col_row  = 2'd0;
      for (int r = 0; r < 4; r++) begin
         if (!row_sync[r]) begin
            col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
            col_row  = 2'(r);
         end
      end

      if (acc_hits == 2'd0)
         tot_hits = col_hits;
      else if (col_hits == 2'd0)
         tot_hits = acc_hits;
      else
         tot_hits = 2'd2;

      scan_pos = (acc_hits != 2'd0) ? acc_pos : {col_row, col_idx};
      scan_hit = (tot_hits == 2'd1);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_cnt  <= '0;
         col_idx  <= 2'd0;
         COL      <= 4'b1110;
         acc_hits <= 2'd0;
         acc_pos  <= 4'd0;
      end else if (slot_end) begin
         div_cnt <= '0;
         col_idx <= next_col;
         COL     <= ~(4'b0001 << next_col);
         if (col_idx == 2'd3) begin
            acc_hits <= 2'd0;
            acc_pos  <= 4'd0;
         end else begin
            acc_hits <= tot_hits;
            acc_pos  <= scan_pos;
         end
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Debounce FSM, stepped once per full-scan result. The result is consumed
   // on the sampling edge itself so KEY_PRESS appears the cycle after it.
   // ------------------------------------------------------------------------
   db_state_t       db_state;
   logic [3:0]      cand_pos;
   logic [DB_W-1:0] db_cnt;
   logic [DB_W-1:0] rel_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         db_state  <= ST_IDLE;
         cand_pos  <= 4'd0;
         db_cnt    <= '0;
         rel_cnt   <= '0;
         KEY_PRESS <= 1'b0;
         KEY_VALUE <= 4'd0;
      end else begin
         KEY_PRESS <= 1'b0;
         if (scan_done) begin
            case (db_state)
               ST_IDLE: begin
                  if (scan_hit) begin
                     cand_pos <= scan_pos;
                     db_cnt   <= DB_W'(1);
                     rel_cnt  <= '0;
                     if (SINGLE_SCAN) begin
                        db_state  <= ST_HELD;
                        KEY_PRESS <= 1'b1;
                        KEY_VALUE <= key_map(scan_pos);
                     end else begin
                        db_state <= ST_DEBOUNCE;
                     end
                  end
               end

               ST_DEBOUNCE: begin
                  if (scan_hit && (scan_pos == cand_pos)) begin
                     db_cnt <= db_cnt + 1'b1;
                     if ((db_cnt + 1'b1) == DB_TARGET) begin
                        db_state  <= ST_HELD;
                        rel_cnt   <= '0;
                        KEY_PRESS <= 1'b1;
                        KEY_VALUE <= key_map(cand_pos);
                     end
                  end else begin
                     db_state <= ST_IDLE;
                     db_cnt   <= '0;
                  end
               end

               ST_HELD: begin
                  // Any key result, even a different key, keeps the hold
                  // alive: a new press needs a full release first.
                  if (scan_hit) begin
                     rel_cnt <= '0;
                  end else if ((rel_cnt + 1'b1) == DB_TARGET) begin
                     db_state <= ST_IDLE;
                     rel_cnt  <= '0;
                     db_cnt   <= '0;
                  end else begin
                     rel_cnt <= rel_cnt + 1'b1;
                  end
               end

               default: begin
                  db_state <= ST_IDLE;
                  db_cnt   <= '0;
                  rel_cnt  <= '0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Entry register. A confirmed entry is shown for the CODE_VALID cycle and
   // cleared on the next one through clear_pend.
   // ------------------------------------------------------------------------
   logic       clear_pend;
   logic [1:0] back_slot;

   assign back_slot = DIGIT_CNT[1:0] - 2'd1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         Code       <= CODE_EMPTY;
         DIGIT_CNT  <= 3'd0;
         CODE_VALID <= 1'b0;
         clear_pend <= 1'b0;
      end else begin
         CODE_VALID <= 1'b0;
         clear_pend <= 1'b0;
         if (CLEAR || clear_pend) begin
            Code      <= CODE_EMPTY;
            DIGIT_CNT <= 3'd0;
         end else if (KEY_PRESS && EN) begin
            if (KEY_VALUE <= 4'd9) begin
               if (DIGIT_CNT < 3'd4) begin
                  Code[{DIGIT_CNT[1:0], 2'b00} +: 4] <= KEY_VALUE;
                  DIGIT_CNT <= DIGIT_CNT + 3'd1;
               end
            end else begin
               case (KEY_VALUE)
                  KEY_BACK: begin
                     if (DIGIT_CNT != 3'd0) begin
                        Code[{back_slot, 2'b00} +: 4] <= NIB_EMPTY;
                        DIGIT_CNT <= DIGIT_CNT - 3'd1;
                     end
                  end
                  KEY_CLR: begin
                     Code      <= CODE_EMPTY;
                     DIGIT_CNT <= 3'd0;
                  end
                  KEY_ENTER: begin
                     if (DIGIT_CNT == 3'd4) begin
                        CODE_VALID <= 1'b1;
                        clear_pend <= 1'b1;
                     end
                  end
                  default: begin
                     // D, * and # carry no entry action.
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_l_modu01_keypad.sv
// ---------------------------------------------------------------------------
// tb_l_modu01_keypad
//
// Self-checking bench for l_modu01_keypad with SCAN_DIV = 8 and
// DEBOUNCE_SCANS = 3 (one full scan = 32 cycles). A small keypad model
// turns a 16-bit pressed-key mask into ROW levels from the driven COL.
// ---------------------------------------------------------------------------
module tb_l_modu01_keypad;

   localparam int SCAN = 32;

   logic        clk;
   logic        rst_n;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        en;
   logic        clear;
   logic        key_press;
   logic [3:0]  key_value;
   logic [15:0] code;
   logic [2:0]  digit_cnt;
   logic        code_valid;

   logic [15:0] key_mask;

   int n_cmp = 0;
   int n_bad = 0;

   l_modu01_keypad #(
      .SCAN_DIV       (8),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .ROW        (row),
      .COL        (col),
      .EN         (en),
      .CLEAR      (clear),
      .KEY_PRESS  (key_press),
      .KEY_VALUE  (key_value),
      .Code       (code),
      .DIGIT_CNT  (digit_cnt),
      .CODE_VALID (code_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad model: a pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_mask[r*4 + c] && !col[c])
               row[r] = 1'b0;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Mask bit for a key code, following the row-major keypad layout.
   function automatic logic [15:0] kbit(input logic [3:0] v);
      int pos;
      case (v)
         4'h1: pos = 0;   4'h2: pos = 1;   4'h3: pos = 2;   4'hA: pos = 3;
         4'h4: pos = 4;   4'h5: pos = 5;   4'h6: pos = 6;   4'hB: pos = 7;
         4'h7: pos = 8;   4'h8: pos = 9;   4'h9: pos = 10;  4'hC: pos = 11;
         4'hE: pos = 12;  4'h0: pos = 13;  4'hF: pos = 14;  default: pos = 15;
      endcase
      return 16'(1) << pos;
   endfunction

   typedef struct {
      logic [15:0] mask;
      int          hold;
      logic        en;
      int          exp_press;
      int          exp_valid;
      logic [15:0] exp_vcode;
      logic [15:0] exp_code;
      logic [2:0]  exp_cnt;
      logic [3:0]  exp_kv;
   } vec_t;

   function automatic vec_t mk(input logic [15:0] mask, input int hold, input logic e,
                               input int np, input int nv, input logic [15:0] vcode,
                               input logic [15:0] c, input logic [2:0] n, input logic [3:0] kv);
      vec_t v;
      v.mask = mask; v.hold = hold; v.en = e; v.exp_press = np; v.exp_valid = nv;
      v.exp_vcode = vcode; v.exp_code = c; v.exp_cnt = n; v.exp_kv = kv;
      return v;
   endfunction

   // Hold a key pattern for 'hold' scans, release for 4 scans, counting pulses.
   task automatic run_keys(input logic [15:0] mask, input int hold,
                           output int np, output int nv, output logic [15:0] vcode);
      np = 0; nv = 0; vcode = 16'h0;
      key_mask = mask;
      for (int i = 0; i < (hold + 4) * SCAN; i++) begin
         if (i == hold * SCAN) key_mask = 16'h0;
         @(negedge clk);
         if (key_press) np++;
         if (code_valid) begin
            nv++;
            vcode = code;
         end
      end
   endtask

   vec_t        vecs [24];
   int          np, nv, found;
   logic [15:0] vcode;

   initial begin
      rst_n = 1'b0; en = 1'b1; clear = 1'b0; key_mask = 16'h0;

      //                 keys                  hold en pr vl vcode     code      cnt  kv
      vecs[0]  = mk(kbit(4'h1),                 4, 1, 1, 0, 16'h0000, 16'hAAA1, 3'd1, 4'h1);
      vecs[1]  = mk(kbit(4'h2),                 4, 1, 1, 0, 16'h0000, 16'hAA21, 3'd2, 4'h2);
      vecs[2]  = mk(kbit(4'h3),                 4, 1, 1, 0, 16'h0000, 16'hA321, 3'd3, 4'h3);
      vecs[3]  = mk(kbit(4'h4),                 4, 1, 1, 0, 16'h0000, 16'h4321, 3'd4, 4'h4);
      vecs[4]  = mk(kbit(4'hA),                 4, 1, 1, 1, 16'h4321, 16'hAAAA, 3'd0, 4'hA);
      vecs[5]  = mk(kbit(4'h5),                 2, 1, 0, 0, 16'h0000, 16'hAAAA, 3'd0, 4'hA);
      vecs[6]  = mk(kbit(4'h5) | kbit(4'h6),    4, 1, 0, 0, 16'h0000, 16'hAAAA, 3'd0, 4'hA);
      vecs[7]  = mk(kbit(4'h5),                20, 1, 1, 0, 16'h0000, 16'hAAA5, 3'd1, 4'h5);
      vecs[8]  = mk(kbit(4'hC),                 4, 1, 1, 0, 16'h0000, 16'hAAAA, 3'd0, 4'hC);
      vecs[9]  = mk(kbit(4'hB),                 4, 1, 1, 0, 16'h0000, 16'hAAAA, 3'd0, 4'hB);
      vecs[10] = mk(kbit(4'h9),                 4, 1, 1, 0, 16'h0000, 16'hAAA9, 3'd1, 4'h9);
      vecs[11] = mk(kbit(4'h8),                 4, 1, 1, 0, 16'h0000, 16'hAA89, 3'd2, 4'h8);
      vecs[12] = mk(kbit(4'hB),                 4, 1, 1, 0, 16'h0000, 16'hAAA9, 3'd1, 4'hB);
      vecs[13] = mk(kbit(4'h1),                 4, 1, 1, 0, 16'h0000, 16'hAA19, 3'd2, 4'h1);
      vecs[14] = mk(kbit(4'h2),                 4, 1, 1, 0, 16'h0000, 16'hA219, 3'd3, 4'h2);
      vecs[15] = mk(kbit(4'h3),                 4, 1, 1, 0, 16'h0000, 16'h3219, 3'd4, 4'h3);
      vecs[16] = mk(kbit(4'h4),                 4, 1, 1, 0, 16'h0000, 16'h3219, 3'd4, 4'h4);
      vecs[17] = mk(kbit(4'hB),                 4, 1, 1, 0, 16'h0000, 16'hA219, 3'd3, 4'hB);
      vecs[18] = mk(kbit(4'hA),                 4, 1, 1, 0, 16'h0000, 16'hA219, 3'd3, 4'hA);
      vecs[19] = mk(kbit(4'hF),                 4, 1, 1, 0, 16'h0000, 16'hA219, 3'd3, 4'hF);
      vecs[20] = mk(kbit(4'h7),                 4, 0, 1, 0, 16'h0000, 16'hA219, 3'd3, 4'h7);
      vecs[21] = mk(kbit(4'h0),                 4, 1, 1, 0, 16'h0000, 16'h0219, 3'd4, 4'h0);
      vecs[22] = mk(kbit(4'hD),                 4, 1, 1, 0, 16'h0000, 16'h0219, 3'd4, 4'hD);
      vecs[23] = mk(kbit(4'hE),                 4, 1, 1, 0, 16'h0000, 16'h0219, 3'd4, 4'hE);

      // ---- Reset values and column rotation --------------------------------
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_col",        32'(col),        32'hE);
      check("rst_code",       32'(code),       32'hAAAA);
      check("rst_digit_cnt",  32'(digit_cnt),  32'd0);
      check("rst_key_press",  32'(key_press),  32'd0);
      check("rst_key_value",  32'(key_value),  32'd0);
      check("rst_code_valid", 32'(code_valid), 32'd0);
      repeat (7) @(negedge clk);
      check("col_slot0_end", 32'(col), 32'hE);
      @(negedge clk);
      check("col_slot1", 32'(col), 32'hD);
      repeat (8) @(negedge clk);
      check("col_slot2", 32'(col), 32'hB);
      repeat (8) @(negedge clk);
      check("col_slot3", 32'(col), 32'h7);
      repeat (8) @(negedge clk);
      check("col_wrap", 32'(col), 32'hE);

      // ---- Table-driven key sequences --------------------------------------
      for (int v = 0; v < 24; v++) begin
         en = vecs[v].en;
         run_keys(vecs[v].mask, vecs[v].hold, np, nv, vcode);
         check($sformatf("v%0d_presses", v),   32'(np),        32'(vecs[v].exp_press));
         check($sformatf("v%0d_valids", v),    32'(nv),        32'(vecs[v].exp_valid));
         if (vecs[v].exp_valid != 0)
            check($sformatf("v%0d_valid_code", v), 32'(vcode), 32'(vecs[v].exp_vcode));
         check($sformatf("v%0d_code", v),      32'(code),      32'(vecs[v].exp_code));
         check($sformatf("v%0d_digit_cnt", v), 32'(digit_cnt), 32'(vecs[v].exp_cnt));
         check($sformatf("v%0d_key_value", v), 32'(key_value), 32'(vecs[v].exp_kv));
      end
      en = 1'b1;

      // ---- CLEAR during the CODE_VALID cycle (entry is 0219, 4 digits) ----
      key_mask = kbit(4'hA);
      found = 0;
      for (int i = 0; i < 8 * SCAN && found == 0; i++) begin
         @(negedge clk);
         if (code_valid) found = 1;
      end
      check("cv_seen", 32'(found), 32'd1);
      check("cv_code_held", 32'(code), 32'h0219);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("cv_pulse_one_cycle", 32'(code_valid), 32'd0);
      check("cv_clear_code",      32'(code),       32'hAAAA);
      check("cv_clear_cnt",       32'(digit_cnt),  32'd0);
      key_mask = 16'h0;
      repeat (4 * SCAN) @(negedge clk);

      // ---- CLEAR on the same cycle as a digit press ------------------------
      run_keys(kbit(4'h6), 4, np, nv, vcode);
      check("pre_clear_code", 32'(code), 32'hAAA6);
      key_mask = kbit(4'h5);
      found = 0;
      for (int i = 0; i < 8 * SCAN && found == 0; i++) begin
         @(negedge clk);
         if (key_press) found = 1;
      end
      check("clr_press_seen", 32'(found), 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      check("clr_code",      32'(code),      32'hAAAA);
      check("clr_digit_cnt", 32'(digit_cnt), 32'd0);
      check("clr_key_value", 32'(key_value), 32'h5);
      key_mask = 16'h0;
      repeat (4 * SCAN) @(negedge clk);

      // ---- Asynchronous reset in the middle of debounce --------------------
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_col",       32'(col),       32'hE);
      check("arst_key_value", 32'(key_value), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      key_mask = kbit(4'h1);
      np = 0;
      // Scan results land on edges 32 and 64: debounce count is 2 here.
      repeat (70) begin
         @(negedge clk);
         if (key_press) np++;
      end
      check("arst_no_early_press", 32'(np), 32'd0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      found = 0;
      for (int i = 1; i <= 5 * SCAN && found == 0; i++) begin
         @(negedge clk);
         if (key_press) found = i;
      end
      // Three fresh scans end on edge 96; the press shows after it.
      check("arst_fresh_latency", 32'(found), 32'd96);
      check("arst_key_value_new", 32'(key_value), 32'h1);
      key_mask = 16'h0;
      repeat (4 * SCAN) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
